// File: rtl/decode_issue_if.sv
// Fetch -> decode/issue -> execute handshake bundle, plus writeback, flush and scoreboard status.
// The master side is fetch/execute/writeback; the slave side is decode_issue_ctrl.
interface decode_issue_if #(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_instr;
  logic [PC_W-1:0]        in_pc;

  logic                   out_valid;
  logic                   out_ready;
  logic [PC_W-1:0]        out_pc;
  logic [6:0]             out_opcode;
  logic [4:0]             out_rd;
  logic [2:0]             out_f3;
  logic [4:0]             out_rs1;
  logic [4:0]             out_rs2;
  logic                   out_f7;

  logic                   wb_valid;
  logic [4:0]             wb_rd;
  logic                   flush;

  logic [31:0]            busy_map;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_f3,
           out_rs1, out_rs2, out_f7, busy_map, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_f3,
           out_rs1, out_rs2, out_f7, busy_map, stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Single-entry decode/issue stage: holds one RV32 instruction, checks RAW hazards against a
// 32-entry pending-write scoreboard, and issues to execute when clear and execute is ready.
module decode_issue_ctrl #(
  parameter int PC_W        = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  decode_issue_if.slave bus
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                 state_reg, state_next;
  logic                   load_en;
  logic [31:0]            instr_reg;
  logic [PC_W-1:0]        pc_reg;
  logic [31:0]            busy_map_reg, busy_map_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

  logic       hold_valid;
  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic       f7;
  logic       uses_rs1, uses_rs2, writes_rd;
  logic       hazard;
  logic       out_valid, issue_fire, in_ready, in_fire;
  logic       unused_instr_bits;

  assign hold_valid = (state_reg == ST_FULL);

  assign opcode = instr_reg[6:0];
  assign rd     = instr_reg[11:7];
  assign f3     = instr_reg[14:12];
  assign rs1    = instr_reg[19:15];
  assign rs2    = instr_reg[24:20];
  assign f7     = instr_reg[30];
  assign unused_instr_bits = ^{instr_reg[31], instr_reg[29:25]};

  always_comb begin
    uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    uses_rs2  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    writes_rd = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && (rd != 5'd0);
  end

  // Registered scoreboard only: a writeback unblocks issue one cycle later, never the same cycle.
  assign hazard     = (uses_rs1 & busy_map_reg[rs1]) | (uses_rs2 & busy_map_reg[rs2]);
  assign out_valid  = hold_valid & ~hazard & ~bus.flush;
  assign issue_fire = out_valid & bus.out_ready;
  assign in_ready   = ~hold_valid | issue_fire;
  assign in_fire    = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    state_next = state_reg;
    load_en    = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_FULL;
          load_en    = 1'b1;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_next = ST_EMPTY;
        end else if (in_fire) begin
          state_next = ST_FULL;
          load_en    = 1'b1;
        end else if (issue_fire) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // Per-register scoreboard update; the issue-side set outranks a same-edge writeback clear.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign busy_map_next[gi] = 1'b0;
      end else begin : g_xn
        logic clr_bit, set_bit;
        assign clr_bit = bus.wb_valid & (bus.wb_rd == 5'(gi));
        assign set_bit = issue_fire & writes_rd & (rd == 5'(gi));
        assign busy_map_next[gi] = set_bit | (busy_map_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (hold_valid && hazard && !bus.flush && !(&stall_cnt_reg)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      busy_map_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      busy_map_reg  <= busy_map_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Payload needs no reset: it is only observed while hold_valid is set.
  always_ff @(posedge clk) begin
    if (load_en) begin
      instr_reg <= bus.in_instr;
      pc_reg    <= bus.in_pc;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_pc     = pc_reg;
  assign bus.out_opcode = opcode;
  assign bus.out_rd     = rd;
  assign bus.out_f3     = f3;
  assign bus.out_rs1    = rs1;
  assign bus.out_rs2    = rs2;
  assign bus.out_f7     = f7;
  assign bus.busy_map   = busy_map_reg;
  assign bus.stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl: decode, RAW stalls, scoreboard set/clear, backpressure,
// flush, throughput and reset, all with hand-computed expectations.
module tb_decode_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  decode_issue_if #(.PC_W(32), .STALL_CNT_W(16)) bus ();

  decode_issue_ctrl #(.PC_W(32), .STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = '0;
    bus.flush     = 1'b0;

    // Reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      bus.busy_map,       32'h0);
    chk("rst_stall",     32'(bus.stall_cnt), 32'd0);
    $display("step reset done");

    // ADD x3,x1,x2 decode and issue
    present(32'h002081B3, 32'h100);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("add_out_valid", 32'(bus.out_valid),  32'd1);
    chk("add_opcode",    32'(bus.out_opcode), 32'h33);
    chk("add_rd",        32'(bus.out_rd),     32'd3);
    chk("add_rs1",       32'(bus.out_rs1),    32'd1);
    chk("add_rs2",       32'(bus.out_rs2),    32'd2);
    chk("add_f3",        32'(bus.out_f3),     32'd0);
    chk("add_f7",        32'(bus.out_f7),     32'd0);
    chk("add_pc",        bus.out_pc,          32'h100);
    tick();
    chk("add_busy",      bus.busy_map,        32'h0000_0008);
    chk("add_empty",     32'(bus.out_valid),  32'd0);
    $display("step add issued busy=%h", bus.busy_map);

    // ADDI x5 then SUB x6,x5,x5 stalls until x5 written back
    present(32'h00100293, 32'h104);
    tick();
    present(32'h40528333, 32'h108);
    settle();
    chk("addi5_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("sub_stall_valid", 32'(bus.out_valid), 32'd0);
    chk("sub_stall_ready", 32'(bus.in_ready),  32'd0);
    chk("sub_busy",        bus.busy_map,       32'h0000_0028);
    chk("sub_stall0",      32'(bus.stall_cnt), 32'd0);
    tick();
    chk("sub_stall1",      32'(bus.stall_cnt), 32'd1);
    tick();
    chk("sub_stall2",      32'(bus.stall_cnt), 32'd2);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    settle();
    chk("sub_no_bypass",   32'(bus.out_valid), 32'd0);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("sub_unblocked",   32'(bus.out_valid), 32'd1);
    chk("sub_f7",          32'(bus.out_f7),    32'd1);
    chk("sub_rd",          32'(bus.out_rd),    32'd6);
    chk("sub_stall3",      32'(bus.stall_cnt), 32'd3);
    tick();
    chk("sub_busy_after",  bus.busy_map,       32'h0000_0048);
    $display("step raw stall done stall_cnt=%0d", bus.stall_cnt);

    // Same-edge set and clear of x7: set wins
    present(32'h00100393, 32'h10C);
    tick();
    present(32'h00100393, 32'h110);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("x7_busy_set",  bus.busy_map,       32'h0000_00C8);
    chk("x7_valid",     32'(bus.out_valid), 32'd1);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("x7_set_wins",  bus.busy_map,       32'h0000_00C8);
    $display("step set/clear collision busy=%h", bus.busy_map);

    // LUI ignores busy sources; STORE writes no rd
    present(32'h00100093, 32'h114);
    tick();
    present(32'h123450B7, 32'h118);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("lui_busy_x1",  bus.busy_map,        32'h0000_00CA);
    chk("lui_no_stall", 32'(bus.out_valid),  32'd1);
    chk("lui_opcode",   32'(bus.out_opcode), 32'h37);
    tick();
    chk("lui_stall",    32'(bus.stall_cnt),  32'd3);
    present(32'h00202223, 32'h11C);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("sw_valid",     32'(bus.out_valid),  32'd1);
    tick();
    chk("sw_no_rd",     bus.busy_map,        32'h0000_00CA);
    $display("step lui/store done busy=%h", bus.busy_map);

    // Backpressure: held contents stable, in_ready low, new offer ignored
    bus.out_ready = 1'b0;
    present(32'h00100213, 32'h120);
    tick();
    present(32'h003004B3, 32'h124);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_valid",    32'(bus.out_valid), 32'd1);
      chk("bp_rd",       32'(bus.out_rd),    32'd4);
      chk("bp_pc",       bus.out_pc,         32'h120);
      chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
      $display("step backpressure cycle %0d rd=%0d", i, bus.out_rd);
      tick();
    end
    // Flush while holding, with an offer present
    bus.flush = 1'b1;
    settle();
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.flush = 1'b1;
    present(32'h00100213, 32'h128);
    settle();
    chk("fl_emptied",   32'(bus.out_valid), 32'd0);
    chk("fl_busy",      bus.busy_map,       32'h0000_00CA);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    chk("fl_not_taken", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready",  32'(bus.in_ready),  32'd1);
    $display("step flush done");

    // rs2-only hazard: ADD x9,x0,x3 with x3 busy
    bus.out_ready = 1'b1;
    present(32'h003004B3, 32'h12C);
    tick();
    bus.in_valid = 1'b0;
    settle();
    chk("rs2_hazard",   32'(bus.out_valid), 32'd0);
    tick();
    chk("rs2_stall4",   32'(bus.stall_cnt), 32'd4);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("rs2_clear",    32'(bus.out_valid), 32'd1);
    chk("rs2_stall5",   32'(bus.stall_cnt), 32'd5);
    chk("rs2_busy",     bus.busy_map,       32'h0000_00C2);
    tick();
    chk("rs2_issued",   bus.busy_map,       32'h0000_02C2);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd20;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    chk("wb_not_busy",  bus.busy_map,       32'h0000_02C2);
    $display("step rs2 hazard done busy=%h", bus.busy_map);

    // Four independent instructions back to back, then reset mid-stream
    present(32'h00100513, 32'h200);
    tick();
    present(32'h00100593, 32'h204);
    settle();
    chk("tp_valid0", 32'(bus.out_valid), 32'd1);
    chk("tp_rd0",    32'(bus.out_rd),    32'd10);
    chk("tp_ready0", 32'(bus.in_ready),  32'd1);
    tick();
    present(32'h00100613, 32'h208);
    settle();
    chk("tp_valid1", 32'(bus.out_valid), 32'd1);
    chk("tp_rd1",    32'(bus.out_rd),    32'd11);
    chk("tp_ready1", 32'(bus.in_ready),  32'd1);
    tick();
    present(32'h00100693, 32'h20C);
    settle();
    chk("tp_valid2", 32'(bus.out_valid), 32'd1);
    chk("tp_rd2",    32'(bus.out_rd),    32'd12);
    chk("tp_ready2", 32'(bus.in_ready),  32'd1);
    tick();
    present(32'h00100713, 32'h210);
    settle();
    chk("tp_valid3", 32'(bus.out_valid), 32'd1);
    chk("tp_rd3",    32'(bus.out_rd),    32'd13);
    chk("tp_pc3",    bus.out_pc,         32'h20C);
    chk("tp_busy",   bus.busy_map,       32'h0000_1EC2);
    $display("step throughput done busy=%h", bus.busy_map);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2_busy",      bus.busy_map,       32'h0);
    chk("rst2_stall",     32'(bus.stall_cnt), 32'd0);
    chk("rst2_in_ready",  32'(bus.in_ready),  32'd1);
    $display("step mid-stream reset done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
